riscv_lsu: RTL

Load-store unit between the core datapath and data memory. It takes one load/store request per instruction from the decoder/ALU, runs a req/ready handshake with data memory, and stalls the core until the access completes. On a load it returns a sign- or zero-extended word. That word is the write-data source for register_file.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/riscv_lsu_if.sv | 36 +++
 rtl/lsu_data_align.sv | 55 +++++
 rtl/riscv_lsu.sv | 106 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the load-store unit: funct3 size codes, FSM state type
// and alignment/legality helpers.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  function automatic logic is_legal_size(input logic [2:0] size);
    case (size)
      LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      LDST_H, LDST_HU: return addr_lo[0];
      LDST_W:          return addr_lo != 2'b00;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side request and data-memory handshake bundle of the load-store unit.
interface riscv_lsu_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              core_req_i;
  logic              core_we_i;
  logic [2:0]        core_size_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [DATA_W-1:0] core_wd_i;
  logic [DATA_W-1:0] core_rd_o;
  logic              core_stall_o;
  logic              core_err_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wd_o;
  logic [DATA_W-1:0] mem_rd_i;
  logic              mem_ready_i;

  // slave: the LSU itself; master: the core/memory environment around it.
  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output core_rd_o, core_stall_o, core_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  core_rd_o, core_stall_o, core_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i
  );
endinterface

// File: rtl/lsu_data_align.sv
// Combinational lane steering: store byte enables / replicated data and
// load byte/halfword extraction with sign or zero extension.
module lsu_data_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_st_size,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_wd,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wd,
  input  logic [2:0]  i_ld_size,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_data,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_ld_shift;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  assign w_ld_shift = i_ld_data >> {i_ld_addr_lo, 3'b000};
  assign w_ld_byte  = w_ld_shift[7:0];
  assign w_ld_half  = i_ld_addr_lo[1] ? i_ld_data[31:16] : i_ld_data[15:0];

  always_comb begin
    o_st_be = 4'b1111;
    o_st_wd = i_st_wd;
    case (i_st_size)
      LDST_B, LDST_BU: begin
        o_st_be = 4'b0001 << i_st_addr_lo;
        o_st_wd = {4{i_st_wd[7:0]}};
      end
      LDST_H, LDST_HU: begin
        o_st_be = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_st_wd = {2{i_st_wd[15:0]}};
      end
      default: begin
        o_st_be = 4'b1111;
        o_st_wd = i_st_wd;
      end
    endcase
  end

  always_comb begin
    o_ld_data = i_ld_data;
    case (i_ld_size)
      LDST_B:  o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      LDST_BU: o_ld_data = {24'd0, w_ld_byte};
      LDST_H:  o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      LDST_HU: o_ld_data = {16'd0, w_ld_half};
      default: o_ld_data = i_ld_data;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: accepts one core request in IDLE, runs the memory req/ready
// handshake in BUSY and presents load data / error in DONE.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  riscv_lsu_if.slave  bus
);

  lsu_state_t        r_state;
  logic              r_we;
  logic [2:0]        r_size;
  logic [1:0]        r_addr_lo;
  logic              r_err;
  logic [DATA_W-1:0] r_rd;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wd;

  logic              w_bad;
  logic [3:0]        w_st_be;
  logic [31:0]       w_st_wd;
  logic [31:0]       w_ld_data;

  assign w_bad = !is_legal_size(bus.core_size_i) ||
                 is_misaligned(bus.core_size_i, bus.core_addr_i[1:0]);

  // Store lanes come from the live request (registered on accept);
  // load extraction uses the fields latched for the running access.
  lsu_data_align u_align (
    .i_st_size    (bus.core_size_i),
    .i_st_addr_lo (bus.core_addr_i[1:0]),
    .i_st_wd      (bus.core_wd_i),
    .o_st_be      (w_st_be),
    .o_st_wd      (w_st_wd),
    .i_ld_size    (r_size),
    .i_ld_addr_lo (r_addr_lo),
    .i_ld_data    (bus.mem_rd_i),
    .o_ld_data    (w_ld_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_size     <= '0;
      r_addr_lo  <= '0;
      r_err      <= 1'b0;
      r_rd       <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_be   <= '0;
      r_mem_addr <= '0;
      r_mem_wd   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.core_req_i) begin
            r_we      <= bus.core_we_i;
            r_size    <= bus.core_size_i;
            r_addr_lo <= bus.core_addr_i[1:0];
            if (w_bad) begin
              r_err   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= bus.core_we_i;
              r_mem_be   <= bus.core_we_i ? w_st_be : 4'b1111;
              r_mem_addr <= {bus.core_addr_i[ADDR_W-1:2], 2'b00};
              r_mem_wd   <= bus.core_we_i ? w_st_wd : '0;
              r_state    <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.mem_ready_i) begin
            r_mem_req <= 1'b0;
            if (!r_we) r_rd <= w_ld_data;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.core_rd_o    = r_rd;
  assign bus.core_err_o   = r_err;
  assign bus.core_stall_o = bus.core_req_i & (r_state != DONE);
  assign bus.mem_req_o    = r_mem_req;
  assign bus.mem_we_o     = r_mem_we;
  assign bus.mem_be_o     = r_mem_be;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_wd_o     = r_mem_wd;

endmodule
